controls_debounce: RTL and testbench



---
 rtl/controls_debounce.sv | 113 +++++++++++
 tb/tb_controls_debounce.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controls_debounce.sv
// controls_debounce
//   Conditions the board's slide switches and push buttons before they reach
//   the processor's control PIO. Each pin is polarity-corrected, passed
//   through a 2-flop synchroniser, then debounced with a per-bit counter
//   clocked by a shared tick prescaler. Rise/fall pulses and a sticky change
//   flag let firmware poll for new input cheaply.
//
// Ports
//   clk50         in   system clock
//   reset_n       in   asynchronous active-low reset
//   raw_in        in   [WIDTH]  raw pin levels (unsynchronised)
//   ctrl_out      out  [WIDTH]  debounced active-high control vector
//   ctrl_rise     out  [WIDTH]  one-cycle pulse on 0->1 of ctrl_out
//   ctrl_fall     out  [WIDTH]  one-cycle pulse on 1->0 of ctrl_out
//   event_pending out  sticky change flag
//   event_ack     in   one-cycle clear request for event_pending
module controls_debounce #(
    parameter int unsigned       WIDTH        = 21,
    parameter logic [WIDTH-1:0]  INVERT_MASK  = {{(WIDTH-3){1'b0}}, 3'b111},
    parameter int unsigned       TICK_CYCLES  = 50000,
    parameter int unsigned       STABLE_TICKS = 16
) (
    input  logic             clk50,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] ctrl_out,
    output logic [WIDTH-1:0] ctrl_rise,
    output logic [WIDTH-1:0] ctrl_fall,
    output logic             event_pending,
    input  logic             event_ack
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [4:0]    CNT_LAST  = 5'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [4:0]       cnt_q [WIDTH];
    logic [4:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             pend_q, pend_d;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        ctrl_d     = ctrl_q;
        rise_d     = '0;
        fall_d     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == ctrl_q[i]) begin
                // Any return to the accepted level restarts qualification.
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Pulses are registered alongside ctrl so they coincide
                    // with the first cycle ctrl_out shows the new level.
                    ctrl_d[i] = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 5'd1;
                end
            end
        end
        // A pending set takes priority over a simultaneous acknowledge.
        if (|(rise_q | fall_q)) begin
            pend_d = 1'b1;
        end else if (event_ack) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            ctrl_q     <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            pend_q     <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_in ^ INVERT_MASK;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            ctrl_q     <= ctrl_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            pend_q     <= pend_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign ctrl_out      = ctrl_q;
    assign ctrl_rise     = rise_q;
    assign ctrl_fall     = fall_q;
    assign event_pending = pend_q;

endmodule

// File: tb/tb_controls_debounce.sv
// Bench for controls_debounce with TICK_CYCLES=4, STABLE_TICKS=3.
// The reference model tracks, per bit, the edge at which the synchronised
// level began to disagree with the accepted level, and counts elapsed ticks
// arithmetically from the global edge index.
module tb_controls_debounce;

    localparam int W  = 21;
    localparam int TC = 4;
    localparam int ST = 3;
    localparam logic [W-1:0] MASK = 21'h000007;

    logic          clk50 = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  raw_in = MASK;
    logic          event_ack = 1'b0;
    logic [W-1:0]  ctrl_out, ctrl_rise, ctrl_fall;
    logic          event_pending;

    int total = 0;
    int bad   = 0;

    controls_debounce #(
        .WIDTH(W),
        .INVERT_MASK(MASK),
        .TICK_CYCLES(TC),
        .STABLE_TICKS(ST)
    ) dut (
        .clk50(clk50),
        .reset_n(reset_n),
        .raw_in(raw_in),
        .ctrl_out(ctrl_out),
        .ctrl_rise(ctrl_rise),
        .ctrl_fall(ctrl_fall),
        .event_pending(event_pending),
        .event_ack(event_ack)
    );

    always #5 clk50 = ~clk50;

    // ---------------- reference model ----------------
    int           k;            // edge index since reset release
    logic [W-1:0] h1, h2;       // active-high input seen 1 and 2 edges ago
    logic [W-1:0] m_ctrl, m_rise, m_fall, m_act;
    logic         m_pend;
    int           m_start [W];
    logic [W-1:0] n_ctrl, n_rise, n_fall, n_act;
    logic         n_pend;
    int           n_start [W];

    always_comb begin
        n_ctrl = m_ctrl;
        n_rise = '0;
        n_fall = '0;
        n_act  = m_act;
        for (int i = 0; i < W; i++) begin
            n_start[i] = m_start[i];
            if (h2[i] == m_ctrl[i]) begin
                n_act[i] = 1'b0;
            end else begin
                if (!m_act[i]) begin
                    n_act[i]   = 1'b1;
                    n_start[i] = k;
                end
                // ticks occur on edges whose index is TC-1 mod TC
                if ((k % TC == TC - 1) && (((k + 1) / TC) - (n_start[i] / TC) == ST)) begin
                    n_ctrl[i] = h2[i];
                    n_rise[i] = h2[i];
                    n_fall[i] = ~h2[i];
                    n_act[i]  = 1'b0;
                end
            end
        end
        n_pend = (|(m_rise | m_fall)) ? 1'b1 : (event_ack ? 1'b0 : m_pend);
    end

    always @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            k      <= 0;
            h1     <= '0;
            h2     <= '0;
            m_ctrl <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_act  <= '0;
            m_pend <= 1'b0;
            for (int i = 0; i < W; i++) m_start[i] <= 0;
        end else begin
            k      <= k + 1;
            h1     <= raw_in ^ MASK;
            h2     <= h1;
            m_ctrl <= n_ctrl;
            m_rise <= n_rise;
            m_fall <= n_fall;
            m_act  <= n_act;
            m_pend <= n_pend;
            for (int i = 0; i < W; i++) m_start[i] <= n_start[i];
        end
    end

    logic [3*W:0] obs_w, exp_w;
    assign obs_w = {ctrl_out, ctrl_rise, ctrl_fall, event_pending};
    assign exp_w = {m_ctrl, m_rise, m_fall, m_pend};

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        raw_in  = MASK;
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d got=%h want=0", c, obs_w);
            end
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL reset_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
    endtask

    task automatic test_clean_press();
        int lat = 0, rises = 0;
        logic pend_after = 1'b0;
        raw_in[0] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL press_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (lat != 0 && c == lat + 1) pend_after = event_pending;
            if (ctrl_out[0] && lat == 0) lat = c;
            if (ctrl_rise[0]) rises++;
        end
        total++;
        if (lat < 11 || lat > 14) begin
            bad++;
            $display("FAIL press_latency got=%0d want=11..14", lat);
        end
        total++;
        if (rises != 1) begin
            bad++;
            $display("FAIL press_rise_count got=%0d want=1", rises);
        end
        total++;
        if (pend_after !== 1'b1) begin
            bad++;
            $display("FAIL press_pending got=%b want=1", pend_after);
        end
    endtask

    task automatic test_bounce();
        int changes = 0, rises = 0;
        logic prev = ctrl_out[5];
        for (int c = 0; c < 90; c++) begin
            if (c < 60 && c % 6 == 0) raw_in[5] = ~raw_in[5];
            if (c == 60) raw_in[5] = 1'b1;
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL bounce_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (ctrl_out[5] !== prev) changes++;
            prev = ctrl_out[5];
            if (ctrl_rise[5]) rises++;
            if (c == 59) begin
                total++;
                if (changes != 0) begin
                    bad++;
                    $display("FAIL bounce_reject got=%0d want=0", changes);
                end
            end
        end
        total++;
        if (changes != 1 || rises != 1 || ctrl_out[5] !== 1'b1) begin
            bad++;
            $display("FAIL bounce_final changes=%0d rises=%0d out=%b want 1/1/1", changes, rises, ctrl_out[5]);
        end
    endtask

    task automatic test_simultaneous();
        int pulse_cycles = 0, both = 0, pc = -1;
        logic pend_after = 1'b0;
        event_ack = 1'b1;
        @(negedge clk50);
        event_ack = 1'b0;
        raw_in[17] = 1'b1;
        raw_in[3]  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL simul_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (pc >= 0 && c == pc + 1) pend_after = event_pending;
            if (|(ctrl_rise | ctrl_fall)) begin
                pulse_cycles++;
                pc = c;
                if (ctrl_rise[17] && ctrl_rise[3]) both++;
            end
        end
        total++;
        if (pulse_cycles != 1 || both != 1 || pend_after !== 1'b1) begin
            bad++;
            $display("FAIL simul_pulses cycles=%0d both=%0d pend=%b want 1/1/1", pulse_cycles, both, pend_after);
        end
    endtask

    task automatic test_ack_collision();
        int found = 0;
        event_ack = 1'b1;
        @(negedge clk50);
        event_ack = 1'b0;
        total++;
        if (event_pending !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear1 got=%b want=0", event_pending);
        end
        raw_in[17] = 1'b0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL ack_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (ctrl_fall[17]) found = 1;
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL ack_fall_timeout got=0 want=1");
        end
        event_ack = 1'b1;
        @(negedge clk50);
        event_ack = 1'b0;
        total++;
        if (event_pending !== 1'b1 || m_pend !== 1'b1) begin
            bad++;
            $display("FAIL ack_collision got=%b want=1", event_pending);
        end
        @(negedge clk50);
        event_ack = 1'b1;
        @(negedge clk50);
        event_ack = 1'b0;
        total++;
        if (event_pending !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear2 got=%b want=0", event_pending);
        end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        raw_in[10] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL rstmid_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
        end
        reset_n = 1'b0;
        @(negedge clk50);
        total++;
        if (ctrl_out[10] !== 1'b0 || obs_w !== '0) begin
            bad++;
            $display("FAIL rstmid_cleared got=%h want=0", obs_w);
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL rstmid_requal cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if (ctrl_out[10] && lat == 0) lat = c;
        end
        total++;
        if (lat < 11 || lat > 14) begin
            bad++;
            $display("FAIL rstmid_latency got=%0d want=11..14", lat);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk50);
            total++;
            if (obs_w !== exp_w) begin
                bad++;
                $display("FAIL random_model cyc%0d got=%h want=%h", c, obs_w, exp_w);
            end
            if ($urandom_range(7) == 0) begin
                int b = $urandom_range(W - 1);
                raw_in[b] = ~raw_in[b];
            end
            event_ack = ($urandom_range(15) == 0);
        end
        event_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_ack_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
